// File: rtl/timer_display.sv
// timer_display: converts the 8-bit countdown seconds value to 3-digit BCD with
// a sequential double-dabble FSM and scans it onto a 4-digit common-anode
// 7-segment display (active-low segments and anodes).
module timer_display #(
    parameter int REFRESH_DIV = 100_000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  count,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp,
    output logic [11:0] bcd,
    output logic        busy,
    output logic        expired
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state;
    logic [11:0]   acc;
    logic [11:0]   adj;
    logic [7:0]    bin;
    logic [2:0]    iter;
    logic [7:0]    last_count;
    logic          have_result;

    logic [CW-1:0] refresh_cnt;
    logic [1:0]    digit_idx;
    logic [1:0]    next_idx;
    logic          wrap;
    logic [3:0]    an_next;
    logic [6:0]    seg_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Add-3 correction of every BCD nibble that is 5 or more, ahead of the shift
    always_comb begin
        adj = acc;
        for (int unsigned i = 0; i < 3; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    // Converter FSM: detect a new count, run 8 shift-add-3 steps, publish result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            acc         <= '0;
            bin         <= '0;
            iter        <= '0;
            last_count  <= '0;
            have_result <= 1'b0;
            bcd         <= '0;
            busy        <= 1'b0;
            expired     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if ((count != last_count) || !have_result) begin
                        bin        <= count;
                        acc        <= '0;
                        last_count <= count;
                        busy       <= 1'b1;
                        iter       <= '0;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    {acc, bin} <= {adj[10:0], bin, 1'b0};
                    iter       <= iter + 3'd1;
                    if (iter == 3'd7)
                        state <= DONE;
                end
                DONE: begin
                    bcd         <= acc;
                    have_result <= 1'b1;
                    expired     <= (acc == '0);
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign wrap     = (refresh_cnt == REFRESH_LAST);
    assign next_idx = digit_idx + 2'd1;
    assign an_next  = ~(4'b0001 << next_idx);

    // Segment pattern for the slot about to be lit, with leading-zero blanking
    always_comb begin
        seg_next = SEG_BLANK;
        if (have_result) begin
            case (next_idx)
                2'd0: seg_next = seg_decode(bcd[3:0]);
                2'd1: if (!(BLANK_LZ && bcd[11:8] == 4'd0 && bcd[7:4] == 4'd0))
                          seg_next = seg_decode(bcd[7:4]);
                2'd2: if (!(BLANK_LZ && bcd[11:8] == 4'd0))
                          seg_next = seg_decode(bcd[11:8]);
                default: seg_next = SEG_BLANK;
            endcase
        end
    end

    // Digit scan: advance one slot per refresh period, registering an/seg together
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_cnt <= '0;
            digit_idx   <= 2'd3;
            an          <= 4'b1111;
            seg         <= SEG_BLANK;
        end else if (wrap) begin
            refresh_cnt <= '0;
            digit_idx   <= next_idx;
            an          <= an_next;
            seg         <= seg_next;
        end else begin
            refresh_cnt <= refresh_cnt + CW'(1);
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_timer_display.sv
// tb_timer_display: table-driven check of the BCD converter and digit scan,
// plus directed sequences for mid-conversion count changes and async reset.
module tb_timer_display;

    localparam int RD = 4;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;

    logic        clk;
    logic        reset;
    logic [7:0]  count;
    logic [6:0]  seg1, seg2;
    logic [3:0]  an1, an2;
    logic        dp1, dp2;
    logic [11:0] bcd1, bcd2;
    logic        busy1, busy2;
    logic        expired1, expired2;

    int errors = 0;
    int checks = 0;

    timer_display #(.REFRESH_DIV(RD), .BLANK_LZ(1'b1)) dut1 (
        .clk(clk), .reset(reset), .count(count), .seg(seg1), .an(an1), .dp(dp1),
        .bcd(bcd1), .busy(busy1), .expired(expired1)
    );

    timer_display #(.REFRESH_DIV(RD), .BLANK_LZ(1'b0)) dut2 (
        .clk(clk), .reset(reset), .count(count), .seg(seg2), .an(an2), .dp(dp2),
        .bcd(bcd2), .busy(busy2), .expired(expired2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  cnt;
        logic [11:0] bcd;
        logic        exp;
        logic [6:0]  s0, s1, s2, s3;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic logic [3:0] an_of(input bit sel);
        return sel ? an2 : an1;
    endfunction

    function automatic logic [6:0] seg_of(input bit sel);
        return sel ? seg2 : seg1;
    endfunction

    // Caller is at a negedge with count already driven; counts busy cycles.
    task automatic wait_conv(output int n);
        n = 0;
        @(negedge clk);
        while (busy1 && n < 20) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_scan(input string tag, input bit sel,
                              input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3);
        logic [6:0] e[4];
        logic [3:0] prev;
        logic [3:0] want_an;
        int first;
        int n;
        int idx;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        prev = an_of(sel);
        n = 0;
        @(negedge clk);
        while (an_of(sel) == prev && n < 3 * RD) begin
            n++;
            @(negedge clk);
        end
        first = -1;
        for (int i = 0; i < 4; i++) begin
            want_an = ~(4'b0001 << i);
            if (an_of(sel) == want_an) first = i;
        end
        chk({tag, " scan_valid"}, {31'd0, first >= 0}, 32'd1);
        if (first < 0) first = 0;
        for (int k = 0; k < 4; k++) begin
            idx = (first + k) % 4;
            want_an = ~(4'b0001 << idx);
            chk({tag, " an"}, {28'd0, an_of(sel)}, {28'd0, want_an});
            chk({tag, " seg"}, {25'd0, seg_of(sel)}, {25'd0, e[idx]});
            repeat (RD) @(negedge clk);
        end
    endtask

    initial begin
        int n;

        vecs[0] = '{8'd20,  12'h020, 1'b0, S0, S2, BL, BL};
        vecs[1] = '{8'd255, 12'h255, 1'b0, S5, S5, S2, BL};
        vecs[2] = '{8'd0,   12'h000, 1'b1, S0, BL, BL, BL};
        vecs[3] = '{8'd7,   12'h007, 1'b0, S7, BL, BL, BL};
        vecs[4] = '{8'd105, 12'h105, 1'b0, S5, S0, S1, BL};
        vecs[5] = '{8'd99,  12'h099, 1'b0, S9, S9, BL, BL};

        reset = 1'b1;
        count = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst bcd", {20'd0, bcd1}, 32'h000);
        chk("rst busy", {31'd0, busy1}, 32'd0);
        chk("rst expired", {31'd0, expired1}, 32'd0);
        chk("rst an", {28'd0, an1}, 32'hf);
        chk("rst seg", {25'd0, seg1}, {25'd0, BL});
        chk("rst dp", {31'd0, dp1}, 32'd1);

        // Release: conversion of 0 starts at once; first wrap lights digit 0, still blank
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_wrap an", {28'd0, an1}, 32'hf);
        @(negedge clk);
        chk("first_wrap an", {28'd0, an1}, 32'he);
        chk("first_wrap seg", {25'd0, seg1}, {25'd0, BL});
        wait_conv(n);
        chk("init bcd", {20'd0, bcd1}, 32'h000);
        chk("init expired", {31'd0, expired1}, 32'd1);

        for (int v = 0; v < 6; v++) begin
            count = vecs[v].cnt;
            wait_conv(n);
            chk($sformatf("v%0d busy_len", v), n, 32'd9);
            chk($sformatf("v%0d busy_end", v), {31'd0, busy1}, 32'd0);
            chk($sformatf("v%0d bcd", v), {20'd0, bcd1}, {20'd0, vecs[v].bcd});
            chk($sformatf("v%0d expired", v), {31'd0, expired1}, {31'd0, vecs[v].exp});
            check_scan($sformatf("v%0d", v), 1'b0, vecs[v].s0, vecs[v].s1, vecs[v].s2, vecs[v].s3);
        end

        // Count changes 20 -> 19 during the third busy cycle
        count = 8'd20;
        n = 0;
        @(negedge clk);
        while (busy1 && n < 20) begin
            n++;
            if (n == 3) count = 8'd19;
            @(negedge clk);
        end
        chk("chg busy_len", n, 32'd9);
        chk("chg first bcd", {20'd0, bcd1}, 32'h020);
        @(negedge clk);
        chk("chg busy_gap", {31'd0, busy1}, 32'd1);
        wait_conv(n);
        chk("chg busy_len2", n, 32'd8);
        chk("chg second bcd", {20'd0, bcd1}, 32'h019);

        // Async reset during the fourth SHIFT cycle
        count = 8'd200;
        repeat (4) @(negedge clk);
        chk("abort busy_before", {31'd0, busy1}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("abort busy", {31'd0, busy1}, 32'd0);
        chk("abort bcd", {20'd0, bcd1}, 32'h000);
        chk("abort an", {28'd0, an1}, 32'hf);
        chk("abort seg", {25'd0, seg1}, {25'd0, BL});
        @(negedge clk);
        count = 8'd7;
        reset = 1'b0;
        wait_conv(n);
        chk("restart busy_len", n, 32'd9);
        chk("restart bcd", {20'd0, bcd1}, 32'h007);

        // No leading-zero blanking on dut2
        count = 8'd5;
        wait_conv(n);
        chk("nolz bcd", {20'd0, bcd2}, 32'h005);
        check_scan("nolz", 1'b1, S5, S0, S0, BL);
        check_scan("lz5", 1'b0, S5, BL, BL, BL);
        chk("dp2", {31'd0, dp2}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
